// File: rtl/uart_rx_pkg.sv
// Shared UART definitions: 2-bit FSM state encoding used by both directions,
// plus a width helper for the bit-timing counter.
package uart_rx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_e;

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_rx_counter.sv
// Modulo-N counter: counts 0..N-1 when ce is high and wraps; ov marks the wrap cycle.
// Synchronous clear has priority over counting.
module uart_rx_counter
  import uart_rx_pkg::*;
#(
  parameter int N = 10,
  localparam int W = cnt_width(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_ce,
  input  logic         i_clr,
  output logic [W-1:0] o_cnt,
  output logic         o_ov
);

  logic [W-1:0] r_cnt;
  logic         w_wrap;

  assign w_wrap = (r_cnt == W'(N - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_ce) begin
      r_cnt <= w_wrap ? '0 : r_cnt + 1'b1;
    end
  end

  assign o_cnt = r_cnt;
  assign o_ov  = i_ce & w_wrap;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop synchronizer, falling-edge start detect,
// mid-bit sampling driven by a single modulo-CPB counter.
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int BAUD = 115200,
  parameter int F    = 50000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx,
  output logic [7:0]  data,
  output logic        valid,
  output logic        frame_err,
  output logic        busy,
  output uart_state_e dbg_state
);

  localparam int CPB  = F / BAUD;
  localparam int HALF = CPB / 2;
  localparam int CW   = cnt_width(CPB);

  logic          r_sync1, r_sync2, r_rxs_prev;
  logic          w_rxs, w_fall;
  uart_state_e   r_state, w_state_nxt;
  logic [2:0]    r_bit_idx, w_bit_idx_nxt;
  logic [7:0]    r_shift, w_shift_nxt;
  logic [7:0]    r_data, w_data_nxt;
  logic          r_valid, w_valid_nxt;
  logic          r_ferr, w_ferr_nxt;
  logic          w_cnt_clr, w_tick, w_half;
  logic [CW-1:0] w_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync1    <= 1'b1;
      r_sync2    <= 1'b1;
      r_rxs_prev <= 1'b1;
    end else begin
      r_sync1    <= rx;
      r_sync2    <= r_sync1;
      r_rxs_prev <= r_sync2;
    end
  end

  assign w_rxs  = r_sync2;
  // Requiring a prior high sample means a held-low line cannot retrigger.
  assign w_fall = r_rxs_prev & ~w_rxs;

  // Counter restarts on the start edge, so HALF-1 lands t0+HALF; restarting it
  // again at mid-start makes every later wrap fall at the centre of a bit.
  uart_rx_counter #(.N(CPB)) u_bit_cnt (
    .clk   (clk),
    .rst   (rst),
    .i_ce  (1'b1),
    .i_clr (w_cnt_clr),
    .o_cnt (w_cnt),
    .o_ov  (w_tick)
  );

  assign w_half = (w_cnt == CW'(HALF - 1));

  always_comb begin
    w_state_nxt   = r_state;
    w_bit_idx_nxt = r_bit_idx;
    w_shift_nxt   = r_shift;
    w_data_nxt    = r_data;
    w_valid_nxt   = 1'b0;
    w_ferr_nxt    = 1'b0;
    w_cnt_clr     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_fall) begin
          w_state_nxt = ST_START;
          w_cnt_clr   = 1'b1;
        end
      end
      ST_START: begin
        if (w_half) begin
          if (!w_rxs) begin
            w_state_nxt   = ST_DATA;
            w_bit_idx_nxt = 3'd0;
            w_cnt_clr     = 1'b1;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
      end
      ST_DATA: begin
        if (w_tick) begin
          w_shift_nxt = {w_rxs, r_shift[7:1]};
          if (r_bit_idx == 3'd7) begin
            w_state_nxt = ST_STOP;
          end else begin
            w_bit_idx_nxt = r_bit_idx + 3'd1;
          end
        end
      end
      ST_STOP: begin
        if (w_tick) begin
          w_state_nxt = ST_IDLE;
          if (w_rxs) begin
            w_valid_nxt = 1'b1;
            w_data_nxt  = r_shift;
          end else begin
            w_ferr_nxt = 1'b1;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= ST_IDLE;
      r_bit_idx <= 3'd0;
      r_shift   <= 8'h00;
      r_data    <= 8'h00;
      r_valid   <= 1'b0;
      r_ferr    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_bit_idx <= w_bit_idx_nxt;
      r_shift   <= w_shift_nxt;
      r_data    <= w_data_nxt;
      r_valid   <= w_valid_nxt;
      r_ferr    <= w_ferr_nxt;
    end
  end

  assign data      = r_data;
  assign valid     = r_valid;
  assign frame_err = r_ferr;
  assign busy      = (r_state != ST_IDLE);
  assign dbg_state = r_state;

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter BAUD, default 115200, serial bit rate in bits/s.
REQ-002 Parameter F, default 50000000, clk frequency in Hz; CPB = F/BAUD (integer division) clocks per bit, HALF = CPB/2.
REQ-003 clk  input  1  single system clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, asynchronous assert, active-low.
REQ-005 rx  input  1  asynchronous serial line; idle high, 8N1 framing, LSB first.
REQ-006 data  output  8  last correctly framed byte; holds value until the next valid frame.
REQ-007 valid  output  1  one-clk pulse marking a new byte on data.
REQ-008 frame_err  output  1  one-clk pulse when the stop bit samples low.
REQ-009 busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-010 rx SHALL pass through a two-flop synchronizer, with both flops reset to 1; all logic uses only the synchronized signal rxs.
REQ-011 The FSM SHALL have states IDLE, START, DATA, STOP.
REQ-012 IDLE: a falling edge on rxs (previous 1, current 0) at cycle t0 SHALL move to START and clear the bit-timing counter.
REQ-013 START: at t0+HALF, rxs==0 -> DATA with bit index 0; rxs==1 -> IDLE as a glitch, with no output pulse.
REQ-014 DATA: bit k (k=0..7) SHALL be sampled at t0+HALF+(k+1)*CPB and shifted in LSB first; after k=7 -> STOP.
REQ-015 STOP: sampled at t0+HALF+9*CPB; rxs==1 -> data updated and valid=1 in the next cycle; rxs==0 -> frame_err=1 in the next cycle, data unchanged; both cases -> IDLE.
REQ-016 After a frame error, IDLE SHALL NOT restart until rxs has been seen high (edge detect), so a break condition produces exactly one frame_err.
REQ-017 valid and frame_err SHALL never both be 1, and each SHALL be exactly one cycle wide.
REQ-018 The bit-timing counter SHALL count 0..CPB-1 and wrap; it SHALL be cleared on every entry to START.
REQ-019 The bit index SHALL be 3 bits and SHALL be used only in DATA.
REQ-020 A falling edge arriving while busy SHALL be ignored.
REQ-021 A new start edge in the cycle the FSM returns to IDLE SHALL be accepted, allowing back-to-back frames with no idle gap.

Reset
REQ-022 While rst==0: state=IDLE, data=8'h00, valid=0, frame_err=0, busy=0, synchronizer flops=1, counters=0.
REQ-023 rst asserted mid-frame SHALL abort the frame immediately with no valid or frame_err pulse.
REQ-024 After release, the next falling edge SHALL start a fresh frame.

Structure
REQ-025 State encodings (2 bits) SHALL live in a shared UART defines include that the transmitter also uses.
REQ-026 Bit timing SHALL reuse the codebase's existing counter sub-module (N=CPB, ce tied to 1, ov as the bit tick), instantiated once; the half-bit offset is applied by preloading or comparison logic in uart_rx.
REQ-027 No other sub-modules are used.

Verification (bench uses F=1000, BAUD=100, giving CPB=10 and HALF=5)
REQ-028 Send 8'hA5 with a correct frame -> valid pulse 1 cycle after the stop sample (t0+96), data=8'hA5, frame_err stays 0.
REQ-029 Send 8'h00 then 8'hFF back-to-back with no idle -> two valid pulses 100 cycles apart, data 8'h00 then 8'hFF.
REQ-030 Pull rx low for 3 cycles, then high -> return to IDLE; no valid, no frame_err, busy high for at most 6 cycles.
REQ-031 Send 8'h3C with stop bit 0, holding rx low for 300 cycles -> exactly one frame_err, data keeps its previous value, no restart until rx goes high.
REQ-032 Assert rst during bit 4 of 8'h55 -> outputs go to reset values at once; the following frame 8'h81 is received correctly.
REQ-033 Loopback with the existing transmitter using default parameters, sending 8'h00..8'hFF -> all 256 bytes received in order with no frame_err.
